// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core control FSM
// (port 0) and the program loader / debug port (port 1). One transaction is
// registered onto the memory strobes at a time. Reads wait RD_LAT cycles for
// the memory, then return data with a one-cycle ack to the owning port.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, ties
// alternate between the two ports. When it is not defined, port 0 has fixed
// priority.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic [1:0]        ack_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic              owner_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C = 3'(RD_LAT);

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       grant_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       last_r;
`endif

  // Pick the port to grant from the current requests; only a tie needs policy.
  always_comb begin
    grant_s = 1'b0;
    case (req_i)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      2'b11:   grant_s = ~last_r;
`else
      2'b11:   grant_s = 1'b0;
`endif
      default: grant_s = 1'b0;
    endcase
  end

  // Transaction FSM: every output is a register, so the strobes, ack and
  // busy flag are all set one state ahead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      ack_o      <= 2'b00;
      rdata_o    <= 32'd0;
      busy_o     <= 1'b0;
      owner_o    <= 1'b0;
      addr_o     <= {ADDR_W{1'b0}};
      wr_en_o    <= 1'b0;
      rd_en_o    <= 1'b0;
      mem_data_o <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_r     <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack_o <= 2'b00;
          if (|req_i) begin
            state_r    <= ISSUE;
            busy_o     <= 1'b1;
            owner_o    <= grant_s;
            addr_o     <= grant_s ? addr1_i : addr0_i;
            mem_data_o <= grant_s ? wdata1_i : wdata0_i;
            wr_en_o    <= we_i[grant_s];
            rd_en_o    <= ~we_i[grant_s];
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_r     <= grant_s;
`endif
          end
        end
        ISSUE: begin
          wr_en_o <= 1'b0;
          rd_en_o <= 1'b0;
          if (wr_en_o) begin
            state_r <= DONE;
            ack_o   <= owner_o ? 2'b10 : 2'b01;
          end else begin
            cnt_r   <= LAT_C;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          // The memory presents data in the last counted cycle.
          if (cnt_r == 3'd1) begin
            rdata_o <= mem_data_i;
            state_r <= DONE;
            ack_o   <= owner_o ? 2'b10 : 2'b01;
          end
        end
        DONE: begin
          ack_o   <= 2'b00;
          busy_o  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ack_o   <= 2'b00;
          busy_o  <= 1'b0;
          wr_en_o <= 1'b0;
          rd_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
